// File: rtl/peripheral_spram_pkg.sv
// Shared types and constants for the peripheral single-port RAM arbiter.
package peripheral_spram_pkg;

    // Arbiter FSM: free arbitration, or a grant held by one port
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // Active-low byte enables all high means a read
    localparam logic [1:0] RD_WEN = 2'b11;

    // Port 0 wins whenever it requests
    function automatic logic [1:0] fixed_gnt(input logic [1:0] req);
        logic [1:0] g;
        g = 2'b00;
        if (req[0]) begin
            g = 2'b01;
        end else if (req[1]) begin
            g = 2'b10;
        end
        return g;
    endfunction

endpackage

// File: rtl/peripheral_spram_arb_rr.sv
// Two-way grant generator for the SPRAM arbiter.
// Macro PERIPHERAL_SPRAM_ARB_ROUND_ROBIN_EN adds a priority pointer that
// favours the port not granted last; without it port 0 always wins.
module peripheral_spram_arb_rr
    import peripheral_spram_pkg::*;
(
`ifdef PERIPHERAL_SPRAM_ARB_ROUND_ROBIN_EN
    input  logic       ram_clk,
    input  logic       ram_rst_n,
    input  logic       upd,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef PERIPHERAL_SPRAM_ARB_ROUND_ROBIN_EN
    logic prio;

    // Pointer moves to the loser whenever an arbitrated access is accepted
    always_ff @(posedge ram_clk) begin
        if (!ram_rst_n) begin
            prio <= 1'b0;
        end else if (upd) begin
            prio <= gnt[0];
        end
    end

    // Priority port first, otherwise the other one
    always_comb begin
        gnt = fixed_gnt(req);
        if (prio) begin
            if (req[1]) begin
                gnt = 2'b10;
            end else if (req[0]) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b00;
            end
        end
    end
`else
    // Fixed priority, no state
    always_comb begin
        gnt = fixed_gnt(req);
    end
`endif

endmodule

// File: rtl/peripheral_spram_arbiter.sv
// Two-port arbiter in front of a single-port RAM with lockable grants,
// out-of-range error responses and a shared read-data bus.
// Optional macro: PERIPHERAL_SPRAM_ARB_ROUND_ROBIN_EN (round-robin in IDLE).
module peripheral_spram_arbiter
    import peripheral_spram_pkg::*;
#(
    parameter int AW       = 6,
    parameter int DW       = 16,
    parameter int MEM_SIZE = 256
) (
    input  logic          ram_clk,
    input  logic          ram_rst_n,
    input  logic [1:0]    req_i,
    input  logic [1:0]    lock_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [1:0]    wen0_i,
    input  logic [1:0]    wen1_i,
    input  logic [DW-1:0] din0_i,
    input  logic [DW-1:0] din1_i,
    output logic [1:0]    gnt_o,
    output logic [1:0]    rvalid_o,
    output logic [1:0]    err_o,
    output logic [DW-1:0] rdata_o,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_cen,
    output logic [1:0]    ram_wen,
    input  logic [DW-1:0] ram_dout
);

    localparam int unsigned WORDS = MEM_SIZE / 2;

    arb_state_t    state;
    arb_state_t    next_state;
    logic [1:0]    arb_gnt;
    logic [1:0]    gnt;
    logic          accepted;
    logic          sel;
    logic [AW-1:0] sel_addr;
    logic [1:0]    sel_wen;
    logic [DW-1:0] sel_din;
    logic          in_range;
    logic          acc_ok;
    logic          acc_read;
    logic          acc_err;
    logic [1:0]    rvalid_q;
    logic [1:0]    err_q;

    peripheral_spram_arb_rr u_arb (
`ifdef PERIPHERAL_SPRAM_ARB_ROUND_ROBIN_EN
        .ram_clk   (ram_clk),
        .ram_rst_n (ram_rst_n),
        .upd       ((state == IDLE) && accepted),
`endif
        .req       (req_i),
        .gnt       (arb_gnt)
    );

    // Grant: arbitrated in IDLE, locked port only otherwise, none in reset
    always_comb begin
        gnt = 2'b00;
        if (ram_rst_n) begin
            case (state)
                IDLE:    gnt = arb_gnt;
                LOCK0:   gnt = {1'b0, req_i[0]};
                LOCK1:   gnt = {req_i[1], 1'b0};
                default: gnt = 2'b00;
            endcase
        end
    end

    // Select the winning port and classify the access
    always_comb begin
        accepted = |(gnt & req_i);
        sel      = gnt[1];
        sel_addr = sel ? addr1_i : addr0_i;
        sel_wen  = sel ? wen1_i  : wen0_i;
        sel_din  = sel ? din1_i  : din0_i;
        in_range = (32'(sel_addr) < 32'(WORDS));
        acc_ok   = accepted && in_range;
        acc_read = acc_ok && (sel_wen == RD_WEN);
        acc_err  = accepted && !in_range;
    end

    // RAM side: forward only in-range accepted accesses, park otherwise
    always_comb begin
        ram_cen  = 1'b1;
        ram_wen  = RD_WEN;
        ram_addr = '0;
        ram_din  = '0;
        if (acc_ok) begin
            ram_cen  = 1'b0;
            ram_wen  = sel_wen;
            ram_addr = sel_addr;
            ram_din  = sel_din;
        end
    end

    // Next state: enter a lock on a locked access, leave on unlock or drop
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accepted && lock_i[sel]) begin
                    next_state = sel ? LOCK1 : LOCK0;
                end
            end
            LOCK0: begin
                if (!req_i[0] || !lock_i[0]) begin
                    next_state = IDLE;
                end
            end
            LOCK1: begin
                if (!req_i[1] || !lock_i[1]) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State and one-cycle response flags; reset discards pending responses
    always_ff @(posedge ram_clk) begin
        if (!ram_rst_n) begin
            state    <= IDLE;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
        end else begin
            state    <= next_state;
            rvalid_q <= acc_read ? gnt : 2'b00;
            err_q    <= acc_err  ? gnt : 2'b00;
        end
    end

    // Read data is only driven while a response is valid
    always_comb begin
        gnt_o    = gnt;
        rvalid_o = rvalid_q;
        err_o    = err_q;
        rdata_o  = (|rvalid_q) ? ram_dout : '0;
    end

endmodule
